// File: rtl/pkt_cell_writer.sv
// pkt_cell_writer: ingress stage in front of the cell allocator.
// Each incoming AXI-S packet claims one cell. Its beats are written straight
// into cell memory, and a {cell_id,len,trunc} descriptor is then offered
// downstream. A packet that gets no cell is consumed, discarded and counted.
// The write path is combinational from the accepted beat, so it adds no latency.
module pkt_cell_writer #(
   parameter int DATA_WIDTH      = 512,
   parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
   parameter int CELL_NUM        = 64,
   parameter int CELL_ID_WIDTH   = $clog2(CELL_NUM),
   parameter int CELL_BEATS      = 24,
   parameter int BEAT_IDX_WIDTH  = $clog2(CELL_BEATS),
   parameter int LEN_WIDTH       = 16,
   parameter bit DROP_ON_INTENSE = 1'b1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [DATA_WIDTH-1:0]                 s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]                 s_axis_tkeep,
   input  logic                                  s_axis_tvalid,
   output logic                                  s_axis_tready,
   input  logic                                  s_axis_tlast,
   output logic                                  alloc_mem_req,
   output logic [LEN_WIDTH-1:0]                  alloc_mem_size,
   input  logic [CELL_ID_WIDTH-1:0]              alloc_cell_id,
   input  logic                                  alloc_mem_success,
   input  logic                                  alloc_mem_intense,
   output logic                                  mem_wr_en,
   output logic [CELL_ID_WIDTH+BEAT_IDX_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0]                 mem_wr_data,
   output logic [KEEP_WIDTH-1:0]                 mem_wr_strb,
   output logic                                  m_desc_valid,
   input  logic                                  m_desc_ready,
   output logic [CELL_ID_WIDTH-1:0]              m_desc_cell_id,
   output logic [LEN_WIDTH-1:0]                  m_desc_len,
   output logic                                  m_desc_trunc,
   output logic [31:0]                           drop_count
);

   localparam int CNT_W = $clog2(KEEP_WIDTH + 1);
   // The beat counter has one extra bit so it can sit at CELL_BEATS, even
   // when CELL_BEATS is a power of two.
   localparam logic [BEAT_IDX_WIDTH:0] BEATS_MAX = (BEAT_IDX_WIDTH + 1)'(CELL_BEATS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DROP  = 2'd2,
      ST_DESC  = 2'd3
   } state_t;

   state_t                     state_q,   state_d;
   logic [CELL_ID_WIDTH-1:0]   cell_id_q, cell_id_d;
   logic [LEN_WIDTH-1:0]       len_q,     len_d;
   logic                       trunc_q,   trunc_d;
   logic [BEAT_IDX_WIDTH:0]    beat_q,    beat_d;
   logic [31:0]                drop_q,    drop_d;

   logic                       tready_c;
   logic                       req_c;
   logic                       wr_en_c;
   logic [CELL_ID_WIDTH-1:0]   wr_id_c;
   logic [BEAT_IDX_WIDTH-1:0]  wr_beat_c;
   logic [CNT_W-1:0]           keep_cnt;

   // Add the byte count to the length, clamping at the all-ones maximum.
   function automatic logic [LEN_WIDTH-1:0] len_add(input logic [LEN_WIDTH-1:0] base,
                                                    input logic [CNT_W-1:0]     cnt);
      logic [LEN_WIDTH:0] sum;
      sum = {1'b0, base} + (LEN_WIDTH + 1)'(cnt);
      return sum[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : sum[LEN_WIDTH-1:0];
   endfunction

   // Count the valid bytes in the current beat.
   always_comb begin
      keep_cnt = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         keep_cnt = keep_cnt + CNT_W'(s_axis_tkeep[i]);
      end
   end

   // Next-state logic and the combinational handshake and write strobes.
   always_comb begin
      state_d   = state_q;
      cell_id_d = cell_id_q;
      len_d     = len_q;
      trunc_d   = trunc_q;
      beat_d    = beat_q;
      drop_d    = drop_q;
      tready_c  = 1'b0;
      req_c     = 1'b0;
      wr_en_c   = 1'b0;
      wr_id_c   = cell_id_q;
      wr_beat_c = '0;

      case (state_q)
         ST_IDLE: begin
            // A request is made only when there is a beat to place, and not
            // while the allocator reports pressure. A grant consumes a cell.
            req_c = s_axis_tvalid & ~(DROP_ON_INTENSE & alloc_mem_intense);
            if (s_axis_tvalid) begin
               tready_c = 1'b1;
               if (req_c && alloc_mem_success) begin
                  cell_id_d = alloc_cell_id;
                  wr_en_c   = 1'b1;
                  wr_id_c   = alloc_cell_id;
                  wr_beat_c = '0;
                  len_d     = len_add('0, keep_cnt);
                  trunc_d   = 1'b0;
                  beat_d    = (BEAT_IDX_WIDTH + 1)'(1);
                  state_d   = s_axis_tlast ? ST_DESC : ST_WRITE;
               end else begin
                  drop_d  = drop_q + 32'd1;
                  state_d = s_axis_tlast ? ST_IDLE : ST_DROP;
               end
            end
         end
         ST_WRITE: begin
            tready_c = 1'b1;
            if (s_axis_tvalid) begin
               if (beat_q < BEATS_MAX) begin
                  wr_en_c   = 1'b1;
                  wr_beat_c = beat_q[BEAT_IDX_WIDTH-1:0];
                  len_d     = len_add(len_q, keep_cnt);
                  beat_d    = beat_q + 1'b1;
               end else begin
                  trunc_d = 1'b1;
               end
               if (s_axis_tlast) begin
                  state_d = ST_DESC;
               end
            end
         end
         ST_DROP: begin
            tready_c = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               state_d = ST_IDLE;
            end
         end
         ST_DESC: begin
            if (m_desc_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers. A cell held at reset is not returned,
   // because the allocator shares this reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cell_id_q <= '0;
         len_q     <= '0;
         trunc_q   <= 1'b0;
         beat_q    <= '0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         cell_id_q <= cell_id_d;
         len_q     <= len_d;
         trunc_q   <= trunc_d;
         beat_q    <= beat_d;
         drop_q    <= drop_d;
      end
   end

   // Combinational outputs are gated by rst_n, so they read zero
   // while reset is held.
   assign s_axis_tready  = rst_n & tready_c;
   assign alloc_mem_req  = rst_n & req_c;
   assign alloc_mem_size = LEN_WIDTH'(CELL_BEATS * KEEP_WIDTH);
   assign mem_wr_en      = rst_n & wr_en_c;
   assign mem_wr_addr    = mem_wr_en ? {wr_id_c, wr_beat_c} : '0;
   assign mem_wr_data    = mem_wr_en ? s_axis_tdata : '0;
   assign mem_wr_strb    = mem_wr_en ? s_axis_tkeep : '0;
   assign m_desc_valid   = (state_q == ST_DESC);
   assign m_desc_cell_id = cell_id_q;
   assign m_desc_len     = len_q;
   assign m_desc_trunc   = trunc_q;
   assign drop_count     = drop_q;

endmodule

// File: tb/tb_pkt_cell_writer.sv
// Testbench for pkt_cell_writer. It runs directed packets and then random
// packets, and checks them against a packet-level reference model.
module tb_pkt_cell_writer;

   localparam int DW = 512;
   localparam int KW = 64;
   localparam int CW = 6;
   localparam int BW = 5;
   localparam int LW = 16;
   localparam int CB = 24;

   logic              clk;
   logic              rst_n;
   logic [DW-1:0]     s_axis_tdata;
   logic [KW-1:0]     s_axis_tkeep;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic              s_axis_tlast;
   logic              alloc_mem_req;
   logic [LW-1:0]     alloc_mem_size;
   logic [CW-1:0]     alloc_cell_id;
   logic              alloc_mem_success;
   logic              alloc_mem_intense;
   logic              mem_wr_en;
   logic [CW+BW-1:0]  mem_wr_addr;
   logic [DW-1:0]     mem_wr_data;
   logic [KW-1:0]     mem_wr_strb;
   logic              m_desc_valid;
   logic              m_desc_ready;
   logic [CW-1:0]     m_desc_cell_id;
   logic [LW-1:0]     m_desc_len;
   logic              m_desc_trunc;
   logic [31:0]       drop_count;

   // Allocator model: when enabled, it grants the current id combinationally.
   logic              grant_en;
   logic [CW-1:0]     grant_id;
   assign alloc_mem_success = alloc_mem_req & grant_en;
   assign alloc_cell_id     = grant_id;

   int checks = 0;
   int errors = 0;
   int drop_model = 0;

   pkt_cell_writer dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_tkeep      (s_axis_tkeep),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tready     (s_axis_tready),
      .s_axis_tlast      (s_axis_tlast),
      .alloc_mem_req     (alloc_mem_req),
      .alloc_mem_size    (alloc_mem_size),
      .alloc_cell_id     (alloc_cell_id),
      .alloc_mem_success (alloc_mem_success),
      .alloc_mem_intense (alloc_mem_intense),
      .mem_wr_en         (mem_wr_en),
      .mem_wr_addr       (mem_wr_addr),
      .mem_wr_data       (mem_wr_data),
      .mem_wr_strb       (mem_wr_strb),
      .m_desc_valid      (m_desc_valid),
      .m_desc_ready      (m_desc_ready),
      .m_desc_cell_id    (m_desc_cell_id),
      .m_desc_len        (m_desc_len),
      .m_desc_trunc      (m_desc_trunc),
      .drop_count        (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance from one sampling point to the next falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [KW-1:0] keep_mask(input int nbytes);
      logic [KW-1:0] k;
      k = '0;
      for (int i = 0; i < nbytes; i++) k[i] = 1'b1;
      return k;
   endfunction

   // Send one packet and check every beat and the outcome against the model.
   // Model: a packet is stored only if the allocator is not under pressure
   // and it grants a cell. A stored packet writes its first CB beats to
   // {id,beat}. Its length is the byte total of those beats, and trunc is
   // set when the packet is longer than CB beats. Any other packet is dropped.
   task automatic send_pkt(input int n, input int last_bytes, input bit intense,
                           input bit grant, input int id, input int hold, input bit gaps);
      bit             stored;
      int             exp_len;
      logic [CW-1:0]  cid;
      logic [KW-1:0]  k;
      logic [CW+BW-1:0] ea;
      stored  = !intense && grant;
      exp_len = 0;
      cid     = CW'(id);
      alloc_mem_intense = intense;
      grant_en          = grant;
      grant_id          = cid;
      for (int b = 0; b < n; b++) begin
         if (gaps && b > 0 && $urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 1'b0;
            #1;
            chk("gap_wr_en", mem_wr_en, 0);
            chk("gap_alloc_req", alloc_mem_req, 0);
            chk("gap_tready", s_axis_tready, 1);
            step();
         end
         k = (b == n - 1) ? keep_mask(last_bytes) : '1;
         s_axis_tdata  = rand_data();
         s_axis_tkeep  = k;
         s_axis_tlast  = (b == n - 1);
         s_axis_tvalid = 1'b1;
         #1;
         chk("tready", s_axis_tready, 1);
         chk("alloc_req", alloc_mem_req, (b == 0 && !intense));
         chk("wr_en", mem_wr_en, (stored && b < CB));
         if (stored && b < CB) begin
            ea = {cid, BW'(b)};
            chk("wr_addr", mem_wr_addr, ea);
            chk("wr_data", mem_wr_data, s_axis_tdata);
            chk("wr_strb", mem_wr_strb, k);
            exp_len += $countones(k);
         end
         step();
      end
      if (stored) begin
         if (exp_len > 65535) exp_len = 65535;
         // Offer a beat of the next packet while the descriptor is pending.
         // It must be neither accepted nor allocated.
         s_axis_tdata  = rand_data();
         s_axis_tkeep  = '1;
         s_axis_tlast  = 1'b0;
         s_axis_tvalid = 1'b1;
         m_desc_ready  = 1'b0;
         for (int h = 0; h < hold; h++) begin
            #1;
            chk("desc_valid_hold", m_desc_valid, 1);
            chk("desc_id_hold", m_desc_cell_id, cid);
            chk("desc_len_hold", m_desc_len, LW'(exp_len));
            chk("desc_trunc_hold", m_desc_trunc, (n > CB));
            chk("desc_tready", s_axis_tready, 0);
            chk("desc_alloc_req", alloc_mem_req, 0);
            chk("desc_wr_en", mem_wr_en, 0);
            step();
         end
         m_desc_ready = 1'b1;
         #1;
         chk("desc_valid", m_desc_valid, 1);
         chk("desc_id", m_desc_cell_id, cid);
         chk("desc_len", m_desc_len, LW'(exp_len));
         chk("desc_trunc", m_desc_trunc, (n > CB));
         chk("desc_tready_hs", s_axis_tready, 0);
         step();
         s_axis_tvalid = 1'b0;
         m_desc_ready  = 1'b0;
         #1;
         chk("desc_valid_after", m_desc_valid, 0);
      end else begin
         drop_model++;
         s_axis_tvalid = 1'b0;
         #1;
         chk("no_desc", m_desc_valid, 0);
      end
      chk("drop_count", drop_count, 32'(drop_model));
      $display("pkt beats=%0d intense=%0b grant=%0b id=%0d stored=%0b drops=%0d", n, intense, grant, id, stored, drop_model);
      @(negedge clk);
   endtask

   initial begin
      rst_n             = 1'b0;
      s_axis_tdata      = '0;
      s_axis_tkeep      = '0;
      s_axis_tvalid     = 1'b0;
      s_axis_tlast      = 1'b0;
      alloc_mem_intense = 1'b0;
      grant_en          = 1'b0;
      grant_id          = '0;
      m_desc_ready      = 1'b0;
      #12;
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_desc_valid", m_desc_valid, 0);
      chk("rst_drop_count", drop_count, 0);
      chk("alloc_size", alloc_mem_size, 16'd1536);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-beat packet with 4 bytes.
      send_pkt(1, 4, 1'b0, 1'b1, 5, 0, 1'b0);
      // Three full beats: 192 bytes.
      send_pkt(3, 64, 1'b0, 1'b1, 9, 1, 1'b0);
      // No grant: the packet is dropped.
      send_pkt(4, 64, 1'b0, 1'b0, 3, 0, 1'b0);
      // Allocator under pressure: no request and a drop. The next packet is stored.
      send_pkt(2, 10, 1'b1, 1'b1, 7, 0, 1'b0);
      send_pkt(2, 10, 1'b0, 1'b1, 7, 0, 1'b0);
      // Oversize packet: 24 writes, then truncation. The descriptor is held for 5 cycles.
      send_pkt(30, 64, 1'b0, 1'b1, 12, 5, 1'b0);
      // Exactly one cell of beats, and one beat over.
      send_pkt(24, 64, 1'b0, 1'b1, 63, 0, 1'b0);
      send_pkt(25, 1, 1'b0, 1'b1, 0, 0, 1'b0);

      // Reset in the middle of a stored packet.
      alloc_mem_intense = 1'b0;
      grant_en          = 1'b1;
      grant_id          = 6'd17;
      for (int b = 0; b < 5; b++) begin
         s_axis_tdata  = rand_data();
         s_axis_tkeep  = '1;
         s_axis_tlast  = 1'b0;
         s_axis_tvalid = 1'b1;
         step();
      end
      #1;
      chk("pre_rst_wr_en", mem_wr_en, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tready", s_axis_tready, 0);
      chk("mid_rst_wr_en", mem_wr_en, 0);
      chk("mid_rst_wr_addr", mem_wr_addr, 0);
      chk("mid_rst_alloc_req", alloc_mem_req, 0);
      chk("mid_rst_desc_valid", m_desc_valid, 0);
      chk("mid_rst_drop_count", drop_count, 0);
      drop_model = 0;
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      send_pkt(3, 33, 1'b0, 1'b1, 22, 0, 1'b0);

      // Random packets.
      for (int p = 0; p < 40; p++) begin
         send_pkt($urandom_range(1, 30), $urandom_range(1, 64),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0),
                  $urandom_range(0, 63), $urandom_range(0, 3), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
